// File: rtl/gelato_types.sv
// gelato_types: shared operation and issue-state types for the compute dispatcher
package gelato_types;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4
  } compute_op_t;
  typedef enum logic {ST_EMPTY, ST_FULL} issue_state_t;
endpackage

// File: rtl/gelato_dispatch_tag_fifo.sv
// gelato_dispatch_tag_fifo: in-order retire tag queue with full/empty flags and same-cycle push/pop
module gelato_dispatch_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_we, w_re;
  assign empty = r_wp == r_rp;
  assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_we  = push && !full;
  assign w_re  = pop && !empty;
  assign dout  = r_mem[r_rp[AW-1:0]];
  // pointers wrap with an extra bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + 1'b1;
      if (w_re) r_rp <= r_rp + 1'b1;
    end
  end
  // storage needs no reset; only the pointers define validity
  always_ff @(posedge clk)
    if (w_we) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/gelato_macros.svh
// gelato_macros: instruction encoding constants for the compute dispatcher decoder
`ifndef GELATO_MACROS_SVH
`define GELATO_MACROS_SVH
`define OPCODE_ARITH  7'b0110011
`define OPCODE_ARITHI 7'b0010011
`define FUNCT3_ADD    3'b000
`define FUNCT3_AND    3'b111
`define FUNCT3_OR     3'b110
`define FUNCT3_XOR    3'b100
`endif

// File: rtl/gelato_compute_dispatcher.sv
// gelato_compute_dispatcher: decode, round-robin issue, in-order retire; GELATO_DISPATCH_PERF_EN adds perf counters
`include "gelato_macros.svh"
module gelato_compute_dispatcher
  import gelato_types::*;
#(
  parameter int THREAD_NUM     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_UNITS      = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int WARP_ID_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     rdy,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [6:0]                               in_opcode,
  input  logic [2:0]                               in_funct3,
  input  logic                                     in_funct7_5,
  input  logic [DATA_WIDTH-1:0]                    in_imm,
  input  logic [REG_ADDR_WIDTH-1:0]                in_rd,
  input  logic [WARP_ID_WIDTH-1:0]                 in_warp,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0]         in_src1,
  input  logic [THREAD_NUM*DATA_WIDTH-1:0]         in_src2,
  output logic [NUM_UNITS-1:0]                     task_valid,
  input  logic [NUM_UNITS-1:0]                     task_ready,
  output logic [3:0]                               task_op,
  output logic [THREAD_NUM*DATA_WIDTH-1:0]         task_rs1,
  output logic [THREAD_NUM*DATA_WIDTH-1:0]         task_rs2,
  input  logic [NUM_UNITS-1:0]                     res_valid,
  output logic [NUM_UNITS-1:0]                     res_ready,
  input  logic [NUM_UNITS*THREAD_NUM*DATA_WIDTH-1:0] res_data,
  output logic                                     wb_valid,
  input  logic                                     wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]                wb_rd,
  output logic [WARP_ID_WIDTH-1:0]                 wb_warp,
  output logic [THREAD_NUM*DATA_WIDTH-1:0]         wb_data,
  output logic                                     err_illegal
`ifdef GELATO_DISPATCH_PERF_EN
  ,
  output logic [31:0]                              perf_issued,
  output logic [31:0]                              perf_retired
`endif
);
  localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
  localparam int LW = THREAD_NUM * DATA_WIDTH;
  localparam int TW = UW + REG_ADDR_WIDTH + WARP_ID_WIDTH;
  issue_state_t r_state, w_state_nxt;
  compute_op_t r_op, w_op;
  logic [LW-1:0] r_rs1, r_rs2, r_wb_data;
  logic [UW-1:0] r_rr, w_rr_inc, w_rr_nxt, w_head_unit;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [WARP_ID_WIDTH-1:0] r_wb_warp;
  logic [TW-1:0] w_head;
  logic r_err, r_wb_valid;
  logic w_legal, w_taken, w_acc, w_push, w_full, w_empty, w_ret;
  // decode: ARITHI ignores funct7_5, ARITH uses it only to pick SUB
  always_comb begin
    w_legal = 1'b0;
    w_op    = OP_ADD;
    if (in_opcode == `OPCODE_ARITHI || in_opcode == `OPCODE_ARITH) begin
      w_legal = 1'b1;
      case (in_funct3)
        `FUNCT3_ADD: w_op = (in_opcode == `OPCODE_ARITH && in_funct7_5) ? OP_SUB : OP_ADD;
        `FUNCT3_AND: w_op = OP_AND;
        `FUNCT3_OR:  w_op = OP_OR;
        `FUNCT3_XOR: w_op = OP_XOR;
        default:     w_legal = 1'b0;
      endcase
    end
  end
  assign w_taken  = rdy && r_state == ST_FULL && task_ready[r_rr];
  assign in_ready = rdy && !rst && (r_state == ST_EMPTY || w_taken) && !w_full;
  assign w_acc    = in_valid && in_ready;
  assign w_push   = w_acc && w_legal;
  assign w_rr_inc = (r_rr == UW'(NUM_UNITS - 1)) ? '0 : r_rr + 1'b1;
  assign w_rr_nxt = w_taken ? w_rr_inc : r_rr;
  // issue register next state: a new accept always refills, a take alone drains
  always_comb begin
    w_state_nxt = w_push ? ST_FULL : (w_taken ? ST_EMPTY : r_state);
  end
  // issue register state
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else r_state <= w_state_nxt;
  end
  // issue payload, round-robin pointer and illegal-encoding pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= OP_ADD;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rr  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && !w_legal;
      if (w_taken) r_rr <= w_rr_inc;
      if (w_push) begin
        r_op  <= w_op;
        r_rs1 <= in_src1;
        r_rs2 <= (in_opcode == `OPCODE_ARITHI) ? {THREAD_NUM{in_imm}} : in_src2;
      end
    end
  end
  assign task_valid  = (r_state == ST_FULL) ? NUM_UNITS'(1) << r_rr : '0;
  assign task_op     = r_op;
  assign task_rs1    = r_rs1;
  assign task_rs2    = r_rs2;
  assign err_illegal = r_err;
  // the tag records the unit the instruction will actually be issued to
  gelato_dispatch_tag_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(TW)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_ret),
    .din   ({w_rr_nxt, in_rd, in_warp}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );
  assign w_head_unit = w_head[TW-1 -: UW];
  assign res_ready   = (rdy && !rst && !w_empty && (!r_wb_valid || wb_ready)) ? NUM_UNITS'(1) << w_head_unit : '0;
  assign w_ret       = |(res_valid & res_ready);
  // write-back register: reload on retire, otherwise drain on wb handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_warp  <= '0;
      r_wb_data  <= '0;
    end else if (w_ret) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= w_head[WARP_ID_WIDTH +: REG_ADDR_WIDTH];
      r_wb_warp  <= w_head[WARP_ID_WIDTH-1:0];
      r_wb_data  <= res_data[w_head_unit*LW +: LW];
    end else if (rdy && wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_warp  = r_wb_warp;
  assign wb_data  = r_wb_data;
`ifdef GELATO_DISPATCH_PERF_EN
  logic [31:0] r_issued, r_retired;
  // task and write-back handshake counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      if (w_taken) r_issued <= r_issued + 1'b1;
      if (rdy && r_wb_valid && wb_ready) r_retired <= r_retired + 1'b1;
    end
  end
  assign perf_issued  = r_issued;
  assign perf_retired = r_retired;
`endif
endmodule

// File: tb/tb_gelato_compute_dispatcher.sv
// tb_gelato_compute_dispatcher: directed self-checking bench for the compute dispatcher
module tb_gelato_compute_dispatcher;
  localparam int TN = 32, DW = 32, NU = 2, QD = 4, WW = 5, RW = 5, LW = TN * DW;
  logic clk = 0, rst = 1, rdy = 1, in_valid = 0, in_funct7_5 = 0, wb_ready = 0;
  logic in_ready, wb_valid, err_illegal;
  logic [6:0] in_opcode = '0;
  logic [2:0] in_funct3 = '0;
  logic [DW-1:0] in_imm = '0;
  logic [RW-1:0] in_rd = '0, wb_rd;
  logic [WW-1:0] in_warp = '0, wb_warp;
  logic [LW-1:0] in_src1 = '0, in_src2 = '0, task_rs1, task_rs2, wb_data;
  logic [NU-1:0] task_valid, res_ready, task_ready = '0, res_valid = '0;
  logic [3:0] task_op;
  logic [NU*LW-1:0] res_data = '0;
  int n_checks = 0, n_fail = 0;

  gelato_compute_dispatcher #(
    .THREAD_NUM(TN), .DATA_WIDTH(DW), .NUM_UNITS(NU), .QUEUE_DEPTH(QD),
    .WARP_ID_WIDTH(WW), .REG_ADDR_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
    .in_imm(in_imm), .in_rd(in_rd), .in_warp(in_warp), .in_src1(in_src1), .in_src2(in_src2),
    .task_valid(task_valid), .task_ready(task_ready), .task_op(task_op),
    .task_rs1(task_rs1), .task_rs2(task_rs2), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_warp(wb_warp), .wb_data(wb_data), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [LW-1:0] rep(input logic [DW-1:0] v);
    return {TN{v}};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [DW-1:0] imm, input logic [RW-1:0] rd, input logic [WW-1:0] warp,
                      input logic [DW-1:0] s1, input logic [DW-1:0] s2);
    in_opcode = opc; in_funct3 = f3; in_funct7_5 = f7; in_imm = imm;
    in_rd = rd; in_warp = warp; in_src1 = rep(s1); in_src2 = rep(s2); in_valid = 1;
    #1;
    for (int n = 0; n < 20 && !in_ready; n++) begin
      @(negedge clk); #1;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_task_valid", task_valid, 0);
    check("rst_task_op", task_op, 0);
    check("rst_task_rs1", 64'(task_rs1 == '0), 1);
    check("rst_task_rs2", 64'(task_rs2 == '0), 1);
    check("rst_res_ready", res_ready, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_warp", wb_warp, 0);
    check("rst_wb_data", 64'(wb_data == '0), 1);
    check("rst_err", err_illegal, 0);
    rst = 0;
    rdy = 0; #1;
    check("rdy_low_in_ready", in_ready, 0);
    rdy = 1;

    // ADDI imm=5, lanes 10 -> unit 0 returns 15
    send(7'b0010011, 3'b000, 1'b0, 32'd5, 5'd3, 5'd7, 32'd10, 32'd99);
    check("addi_task_valid", task_valid, 2'b01);
    check("addi_task_op", task_op, 0);
    check("addi_rs1_lanes", 64'(task_rs1 == rep(32'd10)), 1);
    check("addi_rs2_lanes", 64'(task_rs2 == rep(32'd5)), 1);
    task_ready = 2'b01;
    @(negedge clk);
    task_ready = 0;
    check("addi_task_done", task_valid, 0);
    check("addi_res_ready", res_ready, 2'b01);
    res_valid = 2'b01; res_data[0 +: LW] = rep(32'd15);
    @(negedge clk);
    res_valid = 0;
    check("addi_wb_valid", wb_valid, 1);
    check("addi_wb_data", 64'(wb_data == rep(32'd15)), 1);
    check("addi_wb_rd", wb_rd, 3);
    check("addi_wb_warp", wb_warp, 7);
    @(negedge clk);
    check("addi_wb_hold", wb_valid, 1);
    wb_ready = 1;
    @(negedge clk);
    wb_ready = 0;
    check("addi_wb_drain", wb_valid, 0);

    // three back-to-back ARITH ops rotate units 0,1,0
    do_reset();
    task_ready = 2'b11;
    send(7'b0110011, 3'b000, 1'b0, 32'd0, 5'd1, 5'd2, 32'd1, 32'd2);
    check("rr_a_unit", task_valid, 2'b01);
    check("rr_a_op", task_op, 0);
    send(7'b0110011, 3'b000, 1'b1, 32'd0, 5'd2, 5'd2, 32'd3, 32'd4);
    check("rr_b_unit", task_valid, 2'b10);
    check("rr_b_op_sub", task_op, 1);
    send(7'b0110011, 3'b100, 1'b0, 32'd0, 5'd3, 5'd2, 32'd5, 32'h1234);
    check("rr_c_unit", task_valid, 2'b01);
    check("rr_c_op_xor", task_op, 4);
    check("rr_c_rs2_src2", task_rs2[DW-1:0], 32'h1234);
    @(negedge clk);
    check("rr_idle", task_valid, 0);
    task_ready = 0;

    // unit 1 finishes first; write-back stays in issue order
    res_valid = 2'b10; res_data[LW +: LW] = rep(32'd200); #1;
    check("ord_head_unit0", res_ready, 2'b01);
    @(negedge clk);
    check("ord_wait", wb_valid, 0);
    res_valid = 2'b11; res_data[0 +: LW] = rep(32'd100);
    @(negedge clk);
    res_valid = 2'b10;
    check("ord_first_rd", wb_rd, 1);
    check("ord_first_data", 64'(wb_data == rep(32'd100)), 1);
    #1;
    check("ord_backpressure", res_ready, 0);
    wb_ready = 1; #1;
    check("ord_head_unit1", res_ready, 2'b10);
    @(negedge clk);
    check("ord_second_rd", wb_rd, 2);
    check("ord_second_data", wb_data[DW-1:0], 200);
    res_valid = 2'b01; res_data[0 +: LW] = rep(32'd300);
    @(negedge clk);
    res_valid = 0;
    check("ord_third_rd", wb_rd, 3);
    check("ord_third_data", wb_data[DW-1:0], 300);
    @(negedge clk);
    check("ord_drained", wb_valid, 0);
    wb_ready = 0;

    // illegal encodings pulse err and consume nothing
    send(7'b1111111, 3'b000, 1'b0, 32'd0, 5'd4, 5'd1, 32'd0, 32'd0);
    check("ill_err_pulse", err_illegal, 1);
    check("ill_no_task", task_valid, 0);
    @(negedge clk);
    check("ill_err_clear", err_illegal, 0);
    check("ill_fifo_empty", res_ready, 0);
    send(7'b0110011, 3'b001, 1'b0, 32'd0, 5'd4, 5'd1, 32'd0, 32'd0);
    check("ill_funct3_err", err_illegal, 1);
    send(7'b0010011, 3'b111, 1'b0, 32'd3, 5'd4, 5'd1, 32'd0, 32'd0);
    check("ill_rr_kept", task_valid, 2'b10);
    check("andi_op", task_op, 2);
    #1;
    check("issue_full_in_ready", in_ready, 0);

    // queue full at QUEUE_DEPTH in flight; one retire frees a slot
    do_reset();
    task_ready = 2'b11;
    for (int i = 0; i < QD; i++)
      send(7'b0010011, 3'b110, 1'b0, 32'd1, RW'(10 + i), 5'd0, 32'd0, 32'd0);
    #1;
    check("full_in_ready_0", in_ready, 0);
    @(negedge clk); #1;
    check("full_in_ready_1", in_ready, 0);
    res_valid = 2'b01; res_data[0 +: LW] = rep(32'd42); #1;
    check("full_res_ready", res_ready, 2'b01);
    @(negedge clk);
    res_valid = 0; #1;
    check("full_freed", in_ready, 1);
    check("full_wb_rd", wb_rd, 10);

    // reset with three in flight discards everything
    rst = 1; res_valid = 2'b11; #1;
    check("mid_rst_res_ready", res_ready, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_task_valid", task_valid, 0);
    check("mid_rst_wb_data", 64'(wb_data == '0), 1);
    rst = 0; res_valid = 0; task_ready = 2'b01; #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_fifo_empty", res_ready, 0);
    send(7'b0010011, 3'b000, 1'b0, 32'd7, 5'd9, 5'd4, 32'd1, 32'd0);
    check("post_task_valid", task_valid, 2'b01);
    check("post_rs2", task_rs2[DW-1:0], 7);
    @(negedge clk);
    task_ready = 0;
    check("post_res_ready", res_ready, 2'b01);
    res_valid = 2'b01; res_data[0 +: LW] = rep(32'd8);
    @(negedge clk);
    res_valid = 0;
    check("post_wb_valid", wb_valid, 1);
    check("post_wb_rd", wb_rd, 9);
    check("post_wb_warp", wb_warp, 4);
    check("post_wb_data", 64'(wb_data == rep(32'd8)), 1);
    wb_ready = 1;
    @(negedge clk);
    check("post_wb_drain", wb_valid, 0);
    wb_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gelato_compute_dispatcher.md
# gelato_compute_dispatcher

Parametrised successor of the compute-unit scheduler: decodes arithmetic instructions from the execute stage, issues them round-robin to `NUM_UNITS` compute units, and retires results to the register write-back port in strict issue order. It sits between the warp issue stage and the SIMT compute units. Unlike the single-shot scheduler, it keeps up to `QUEUE_DEPTH` instructions in flight and reports illegal encodings instead of halting simulation.

## Interface
Parameters:
- `THREAD_NUM`, 32, lanes per warp
- `DATA_WIDTH`, 32, bits per lane
- `NUM_UNITS`, 2, compute units, at least 1
- `QUEUE_DEPTH`, 4, in-flight tag entries, power of two, at least 2
- `WARP_ID_WIDTH`, 5, width of the warp identifier
- `REG_ADDR_WIDTH`, 5, width of the destination register address

Ports:
- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global enable; when low, all state holds and handshakes are ignored
- `in_valid`/`in_ready` in/out 1: instruction handshake
- `in_opcode` in 7, `in_funct3` in 3, `in_funct7_5` in 1: encoding fields
- `in_imm` in DATA_WIDTH: immediate
- `in_rd` in REG_ADDR_WIDTH, `in_warp` in WARP_ID_WIDTH: destination register and warp
- `in_src1`, `in_src2` in THREAD_NUM*DATA_WIDTH: operands
- `task_valid`/`task_ready` out/in NUM_UNITS: per-unit one-hot issue handshake
- `task_op` out 4, `task_rs1`, `task_rs2` out THREAD_NUM*DATA_WIDTH: shared issue bus
- `res_valid` in NUM_UNITS, `res_ready` out NUM_UNITS, `res_data` in NUM_UNITS*THREAD_NUM*DATA_WIDTH: unit results
- `wb_valid`/`wb_ready` out/in 1, `wb_rd`, `wb_warp`, `wb_data`: write-back
- `err_illegal` out 1: one-cycle pulse on an illegal encoding

## Operation
- Decode for opcode `0010011` (ARITHI): funct3 000→ADD, 111→AND, 110→OR, 100→XOR. `rs2` is `in_imm` replicated across all THREAD_NUM lanes.
- Decode for opcode `0110011` (ARITH): funct3 000 with funct7_5=0→ADD, funct3 000 with funct7_5=1→SUB, 111→AND, 110→OR, 100→XOR. `rs2` is `in_src2`.
- Any other encoding is illegal. It is accepted, dropped, and raises `err_illegal` one cycle later. It takes no queue entry and does not advance the round-robin pointer.
- Issue register state machine:
  - EMPTY → FULL on accept.
  - FULL → EMPTY when `task_ready[rr_ptr]` is high and no new accept occurs.
  - FULL → FULL when the current task is taken and a new accept happens in the same cycle.
- `in_ready` = `rdy` && !`rst` && (issue register EMPTY, or its task is taken this cycle) && tag FIFO not full.
- Accept pushes the tag {unit=rr_ptr, rd, warp}. After a task is taken, `rr_ptr` advances by 1 modulo NUM_UNITS.
- Retire path:
  - The FIFO head selects a unit. `res_ready[head.unit]` = FIFO non-empty && (`wb_valid`=0 || `wb_ready`).
  - On a result handshake: load the write-back register and pop the FIFO.
- Units return results in their own issue order. Results from non-head units wait.
- Push and pop in the same cycle leave the FIFO count unchanged. When the FIFO is full, `in_ready` is low.
- Arithmetic is per lane, DATA_WIDTH bits, modulo 2^DATA_WIDTH, with no flags.

## Timing
- Reset values: `in_ready`=0, `task_valid`=0, `task_op`=0, `task_rs1`=0, `task_rs2`=0, `res_ready`=0, `wb_valid`=0, `wb_rd`=0, `wb_warp`=0, `wb_data`=0, `err_illegal`=0. The FIFO is empty and `rr_ptr`=0.
- Issue latency: accept at cycle N → `task_valid` at N+1. It is held stable until `task_ready`.
- Retire latency: result handshake at cycle M → `wb_valid` at M+1. It is held until `wb_ready`.
- Sustained throughput is one instruction per cycle when units and write-back never stall.
- `rst` asserted mid-operation: all in-flight work is discarded and the reset values apply at the next edge. Results presented during reset are ignored.

## Configuration
- `GELATO_DISPATCH_PERF_EN`:
  - Defined: adds outputs `perf_issued` and `perf_retired`, 32 bits each. They increment on a task handshake and a wb handshake respectively, wrap modulo 2^32, and reset to 0.
  - Undefined: the ports and counters are absent.

## Structure
- Package `gelato_types`: `compute_op_t` enum, encoded ADD=0, SUB=1, AND=2, OR=3, XOR=4.
- `gelato_macros.svh`: `OPCODE_ARITH`, `OPCODE_ARITHI`, `FUNCT3_*` constants.
- Sub-module `gelato_dispatch_tag_fifo`: parametrised depth/width, synchronous reset, full/empty flags, simultaneous push/pop.

## Test plan
- ADDI, imm=5, src1 lanes all 10 → `task_op`=ADD and `task_rs2` lanes all 5 at N+1. Unit returns 15 → `wb_data` lanes 15, correct `wb_rd`/`wb_warp`.
- Three back-to-back ARITH ADDs with NUM_UNITS=2 → tasks go to units 0, 1, 0.
- Unit 1 result arrives before unit 0 → write-back order is still unit 0 then unit 1.
- QUEUE_DEPTH=4, hold `res_valid`=0, issue 4 instructions → `in_ready`=0. One retire → `in_ready`=1 next cycle.
- opcode `1111111` → `err_illegal` pulse for one cycle, no task issued, FIFO count unchanged.
- Assert `rst` with 3 instructions in flight → `wb_valid`=0 and FIFO empty next cycle; a new ADDI then completes normally.
